led_bus_sequencer: RTL and testbench
====================================

Name: led_bus_sequencer

Overview:
- Bus initiator for the 8-bit write-only LED register bus (write_enable / write_address / write_data).
- On a start request it enables the LED peripheral and then periodically writes an animated 16-bit pattern into its two data registers. On a stop request it disables the peripheral.
- Sits between board buttons/switches and the LED register peripheral, and drives that peripheral's write port directly.

Parameters:
- TICK_DIV, 12500000, cycles between successive pattern updates (8 Hz at 100 MHz); legal range >= 4.
- CTRL_ADDR, 8'h00, address of the peripheral control register (bit0 = LED enable).
- DATA1_ADDR, 8'h01, address of the low data byte (led[7:0]).
- DATA2_ADDR, 8'h02, address of the high data byte (led[15:8]).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  level/pulse; request to begin the sequence, sampled at each rising edge.
- stop  input  1  level/pulse; request to end the sequence, sampled at each rising edge.
- mode  input  2  pattern mode: 00 static, 01 rotate left, 10 rotate right, 11 increment.
- seed  input  16  initial pattern, captured when start is accepted.
- write_enable  output  1  one-cycle write strobe to the peripheral.
- write_address  output  8  register address; valid while write_enable=1, else 8'h00.
- write_data  output  8  write data; valid while write_enable=1, else 8'h00.
- busy  output  1  high while the sequence is active.

Behaviour:
- All outputs are registered. On rst: write_enable=0, write_address=8'h00, write_data=8'h00, busy=0, state=IDLE, pattern=16'h0000, tick counter=0, stop_pending=0.
- Reset mid-operation aborts immediately and issues no disable write. The peripheral is expected to share rst.
- States: IDLE, EN, WR_LO, WR_HI, WAIT, DIS.
- Each of EN, WR_LO, WR_HI and DIS lasts exactly one cycle with write_enable=1. WAIT has write_enable=0.
- IDLE: start=1 and stop=0 at edge N → pattern<=seed, state EN.
  - Cycle N+1: {CTRL_ADDR, 8'h01}, busy=1.
  - Cycle N+2: {DATA1_ADDR, pattern[7:0]}.
  - Cycle N+3: {DATA2_ADDR, pattern[15:8]}.
  - Then WAIT.
- start and stop both high in IDLE: stop wins and the block stays IDLE.
- start while busy is ignored.
- WAIT: lasts TICK_DIV-2 cycles. On the last WAIT cycle, pattern updates per the current mode:
  - 00: unchanged.
  - 01: {p[14:0],p[15]}.
  - 10: {p[0],p[15:1]}.
  - 11: p+1, wrapping 16'hFFFF→16'h0000.
- After WAIT comes WR_LO, so WR_LO strobes occur exactly TICK_DIV cycles apart.
- mode is sampled only at the update. A mode change mid-WAIT therefore takes effect at the next update.
- WR_LO→WR_HI is atomic and is never split by stop.
- stop=1 while busy sets stop_pending.
  - In WAIT, the next cycle is DIS.
  - In EN/WR_LO/WR_HI, the pair completes and DIS follows WR_HI.
- DIS drives {CTRL_ADDR, 8'h00}. The next state is IDLE; busy drops to 0 the cycle after DIS, and stop_pending clears.
- busy is 1 from the EN cycle through the DIS cycle inclusive.
- start is accepted again in the first IDLE cycle after DIS.

Test Plan:
1. TICK_DIV=8, rst, seed=16'hA5C3, mode=00, start pulse at edge N → writes (00,01)@N+1, (01,C3)@N+2, (02,A5)@N+3. Then identical (01,C3),(02,A5) pairs with WR_LO at N+10, N+18, …; busy=1.
2. seed=16'h8001, mode=01 → successive pairs write patterns 8001, 0003, 0006, 000C. With mode=10 from seed 0001: 0001, 8000, 4000.
3. seed=16'hFFFF, mode=11 → second pair writes (01,00),(02,00), i.e. wrap to 0000; the next pair writes 0001.
4. stop pulse during WR_LO cycle → WR_HI still occurs next cycle, then (00,00) write, then busy=0. stop during WAIT → (00,00) on the next cycle.
5. start and stop asserted together in IDLE → no writes and busy stays 0. start pulsed while busy → pattern timing unchanged.
6. rst asserted mid-WAIT and mid-WR_LO → next cycle write_enable=0, address/data=00, busy=0. A subsequent start restarts cleanly from seed.

Source files
------------

// File: rtl/led_bus_sequencer_if.sv
// rtl/led_bus_sequencer_if.sv - write-only LED register bus (strobe, address, data)
interface led_bus_sequencer_if;
  logic       write_enable;
  logic [7:0] write_address;
  logic [7:0] write_data;

  modport master (
    output write_enable,
    output write_address,
    output write_data
  );

  modport slave (
    input write_enable,
    input write_address,
    input write_data
  );
endinterface

// File: rtl/led_bus_sequencer.sv
// rtl/led_bus_sequencer.sv - enables the LED peripheral and periodically writes an animated 16-bit pattern
module led_bus_sequencer #(
  parameter int         TICK_DIV   = 12500000,
  parameter logic [7:0] CTRL_ADDR  = 8'h00,
  parameter logic [7:0] DATA1_ADDR = 8'h01,
  parameter logic [7:0] DATA2_ADDR = 8'h02
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [1:0]                 mode,
  input  logic [15:0]                seed,
  output logic                       busy,
  led_bus_sequencer_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN    = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    WAIT  = 3'd4,
    DIS   = 3'd5
  } state_t;

  // WAIT spans TICK_DIV-2 cycles so that WR_LO strobes land TICK_DIV cycles apart.
  localparam int          CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TICK_DIV - 3);

  state_t        state;
  state_t        next_state;
  logic [15:0]   pattern;
  logic [15:0]   pattern_d;
  logic [15:0]   pattern_upd;
  logic [CW-1:0] tick_cnt;
  logic          stop_pending;
  logic          stop_any;
  logic          wait_last;

  logic          we_d;
  logic [7:0]    addr_d;
  logic [7:0]    data_d;
  logic          busy_d;
  logic          we_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;

  assign stop_any  = stop | stop_pending;
  assign wait_last = (tick_cnt == WAIT_LAST);

  // Pattern animation step for the currently selected mode.
  always_comb begin
    pattern_upd = pattern;
    case (mode)
      2'b00:   pattern_upd = pattern;
      2'b01:   pattern_upd = {pattern[14:0], pattern[15]};
      2'b10:   pattern_upd = {pattern[0], pattern[15:1]};
      default: pattern_upd = pattern + 16'd1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; WR_LO always proceeds to WR_HI so a data pair is never split.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = (start && !stop) ? EN : IDLE;
      EN:      next_state = WR_LO;
      WR_LO:   next_state = WR_HI;
      WR_HI:   next_state = stop_any ? DIS : WAIT;
      WAIT: begin
        if (stop_any)       next_state = DIS;
        else if (wait_last) next_state = WR_LO;
        else                next_state = WAIT;
      end
      DIS:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next pattern value: seed on acceptance, animation step when WAIT hands over to WR_LO.
  always_comb begin
    pattern_d = pattern;
    if (state == IDLE && start && !stop) begin
      pattern_d = seed;
    end else if (state == WAIT && next_state == WR_LO) begin
      pattern_d = pattern_upd;
    end
  end

  // Pattern, WAIT tick counter and latched stop request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern      <= 16'h0000;
      tick_cnt     <= '0;
      stop_pending <= 1'b0;
    end else begin
      pattern      <= pattern_d;
      tick_cnt     <= (state == WAIT && next_state == WAIT) ? tick_cnt + CW'(1) : '0;
      stop_pending <= (next_state != IDLE) &&
                      (stop_pending || (stop && state != IDLE));
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    we_d   = 1'b0;
    addr_d = 8'h00;
    data_d = 8'h00;
    busy_d = (next_state != IDLE);
    case (next_state)
      EN: begin
        we_d   = 1'b1;
        addr_d = CTRL_ADDR;
        data_d = 8'h01;
      end
      WR_LO: begin
        we_d   = 1'b1;
        addr_d = DATA1_ADDR;
        data_d = pattern_d[7:0];
      end
      WR_HI: begin
        we_d   = 1'b1;
        addr_d = DATA2_ADDR;
        data_d = pattern_d[15:8];
      end
      DIS: begin
        we_d   = 1'b1;
        addr_d = CTRL_ADDR;
        data_d = 8'h00;
      end
      default: begin
        we_d   = 1'b0;
        addr_d = 8'h00;
        data_d = 8'h00;
      end
    endcase
  end

  // Output registers; reset drops the bus to idle without a disable write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= 8'h00;
      data_q <= 8'h00;
      busy   <= 1'b0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy   <= busy_d;
    end
  end

  assign bus.write_enable  = we_q;
  assign bus.write_address = addr_q;
  assign bus.write_data    = data_q;

endmodule

// File: tb/tb_led_bus_sequencer.sv
// tb/tb_led_bus_sequencer.sv - table-driven bench for led_bus_sequencer
module tb_led_bus_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic        busy;

  led_bus_sequencer_if bus_if ();

  led_bus_sequencer #(
    .TICK_DIV   (8),
    .CTRL_ADDR  (8'h00),
    .DATA1_ADDR (8'h01),
    .DATA2_ADDR (8'h02)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .seed  (seed),
    .busy  (busy),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] seed;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  // Inputs are applied before an edge; expected outputs are those seen right after it.
  task automatic add_vec(input logic r, input logic st, input logic sp, input logic [1:0] m,
                         input logic [15:0] s, input logic we, input logic [7:0] a,
                         input logic [7:0] d, input logic b);
    vec_t v;
    v.rst = r; v.start = st; v.stop = sp; v.mode = m; v.seed = s;
    v.we = we; v.addr = a; v.data = d; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic add_wait(input int n, input logic [1:0] m);
    for (int k = 0; k < n; k++) add_vec(1'b0, 1'b0, 1'b0, m, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic add_idle();
    add_vec(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic add_wr(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d);
    add_vec(1'b0, 1'b0, 1'b0, m, 16'h0000, 1'b1, a, d, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int first_lo;
  int second_lo;
  int gap_ok;
  int dis_seen;
  int busy_dropped;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; seed = 16'h0000;

    // Static pattern, ignored start while busy, stop during WAIT.
    add_vec(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0);
    add_idle();
    add_vec(1'b0, 1'b1, 1'b0, 2'b00, 16'hA5C3, 1'b1, 8'h00, 8'h01, 1'b1);
    add_wr(2'b00, 8'h01, 8'hC3);
    add_wr(2'b00, 8'h02, 8'hA5);
    add_wait(2, 2'b00);
    add_vec(1'b0, 1'b1, 1'b0, 2'b00, 16'h1111, 1'b0, 8'h00, 8'h00, 1'b1);
    add_wait(3, 2'b00);
    add_wr(2'b00, 8'h01, 8'hC3);
    add_wr(2'b00, 8'h02, 8'hA5);
    add_wait(1, 2'b00);
    add_vec(1'b0, 1'b0, 1'b1, 2'b00, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b1);
    add_idle();
    add_vec(1'b0, 1'b1, 1'b1, 2'b00, 16'hFFFF, 1'b0, 8'h00, 8'h00, 1'b0);
    add_idle();

    // Rotate left from 8001; stop during WR_LO still completes the pair.
    add_vec(1'b0, 1'b1, 1'b0, 2'b01, 16'h8001, 1'b1, 8'h00, 8'h01, 1'b1);
    add_wr(2'b01, 8'h01, 8'h01);
    add_wr(2'b01, 8'h02, 8'h80);
    add_wait(6, 2'b01);
    add_wr(2'b01, 8'h01, 8'h03);
    add_wr(2'b01, 8'h02, 8'h00);
    add_wait(6, 2'b01);
    add_wr(2'b01, 8'h01, 8'h06);
    add_vec(1'b0, 1'b0, 1'b1, 2'b01, 16'h0000, 1'b1, 8'h02, 8'h00, 1'b1);
    add_vec(1'b0, 1'b0, 1'b0, 2'b01, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b1);
    add_idle();

    // Rotate right from 0001; stop during WR_HI.
    add_vec(1'b0, 1'b1, 1'b0, 2'b10, 16'h0001, 1'b1, 8'h00, 8'h01, 1'b1);
    add_wr(2'b10, 8'h01, 8'h01);
    add_wr(2'b10, 8'h02, 8'h00);
    add_wait(6, 2'b10);
    add_wr(2'b10, 8'h01, 8'h00);
    add_wr(2'b10, 8'h02, 8'h80);
    add_wait(6, 2'b10);
    add_wr(2'b10, 8'h01, 8'h00);
    add_wr(2'b10, 8'h02, 8'h40);
    add_vec(1'b0, 1'b0, 1'b1, 2'b10, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b1);
    add_idle();

    // Increment wraps FFFF -> 0000 -> 0001; reset mid-WAIT.
    add_vec(1'b0, 1'b1, 1'b0, 2'b11, 16'hFFFF, 1'b1, 8'h00, 8'h01, 1'b1);
    add_wr(2'b11, 8'h01, 8'hFF);
    add_wr(2'b11, 8'h02, 8'hFF);
    add_wait(6, 2'b11);
    add_wr(2'b11, 8'h01, 8'h00);
    add_wr(2'b11, 8'h02, 8'h00);
    add_wait(6, 2'b11);
    add_wr(2'b11, 8'h01, 8'h01);
    add_wr(2'b11, 8'h02, 8'h00);
    add_wait(1, 2'b11);
    add_vec(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0);
    add_idle();

    // Mode switched mid-WAIT applies at the update; reset mid-WR_LO; clean restart.
    add_vec(1'b0, 1'b1, 1'b0, 2'b01, 16'h0003, 1'b1, 8'h00, 8'h01, 1'b1);
    add_wr(2'b01, 8'h01, 8'h03);
    add_wr(2'b01, 8'h02, 8'h00);
    add_wait(2, 2'b01);
    add_wait(4, 2'b11);
    add_wr(2'b11, 8'h01, 8'h04);
    add_vec(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0);
    add_idle();
    add_vec(1'b0, 1'b1, 1'b0, 2'b00, 16'h1234, 1'b1, 8'h00, 8'h01, 1'b1);
    add_wr(2'b00, 8'h01, 8'h34);
    add_wr(2'b00, 8'h02, 8'h12);
    add_wait(2, 2'b00);
    add_vec(1'b0, 1'b0, 1'b1, 2'b00, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b1);
    add_idle();

    for (int i = 0; i < vecs.size(); i++) begin
      rst   = vecs[i].rst;
      start = vecs[i].start;
      stop  = vecs[i].stop;
      mode  = vecs[i].mode;
      seed  = vecs[i].seed;
      tick();
      checks++;
      if (bus_if.write_enable !== vecs[i].we || bus_if.write_address !== vecs[i].addr ||
          bus_if.write_data !== vecs[i].data || busy !== vecs[i].busy) begin
        errors++;
        $display("FAIL vec%0d: got we=%b addr=%h data=%h busy=%b, want we=%b addr=%h data=%h busy=%b",
                 i, bus_if.write_enable, bus_if.write_address, bus_if.write_data, busy,
                 vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].busy);
      end
    end

    // WR_LO strobes are exactly TICK_DIV cycles apart.
    rst = 1'b0; stop = 1'b0; mode = 2'b00; seed = 16'h0F0F; start = 1'b1;
    first_lo = -1;
    second_lo = -1;
    for (int i = 0; i < 40 && second_lo < 0; i++) begin
      tick();
      start = 1'b0;
      if (bus_if.write_enable && bus_if.write_address == 8'h01) begin
        if (first_lo < 0) first_lo = i;
        else second_lo = i;
      end
    end
    gap_ok = (first_lo >= 0 && second_lo >= 0 && (second_lo - first_lo) == 8) ? 1 : 0;
    checks++;
    if (gap_ok == 0) begin
      errors++;
      $display("FAIL wr_lo_gap: got first=%0d second=%0d, want spacing 8", first_lo, second_lo);
    end

    // Stop must produce a disable write and then drop busy within a bounded window.
    stop = 1'b1;
    dis_seen = 0;
    busy_dropped = 0;
    for (int i = 0; i < 20 && busy_dropped == 0; i++) begin
      tick();
      stop = 1'b0;
      if (bus_if.write_enable && bus_if.write_address == 8'h00 && bus_if.write_data == 8'h00)
        dis_seen = 1;
      if (!busy) busy_dropped = 1;
    end
    checks++;
    if (dis_seen == 0 || busy_dropped == 0) begin
      errors++;
      $display("FAIL stop_shutdown: got dis=%0d busy_low=%0d, want dis=1 busy_low=1",
               dis_seen, busy_dropped);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
